mux_n_to_1_scan: RTL



---
 rtl/mux_n_to_1_scan_if.sv | 39 +++
 rtl/mux_n_to_1_scan.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/mux_n_to_1_scan_if.sv
// Channel bus for the scanning N-to-1 mux: packed inputs, controls and registered outputs.
// Latency: none (wires only).
// Backpressure: none; the consumer samples DOUT when DOUT_VALID is high.
// Optional feature macro: MUX_MASK_EN adds the per-channel MASK input.
interface mux_n_to_1_scan_if #(
   parameter int N    = 4,
   parameter int W    = 1,
   parameter int SELW = $clog2(N)
);
   logic            EN;
   logic            MODE;
   logic [SELW-1:0] SEL;
   logic [N*W-1:0]  DIN;
`ifdef MUX_MASK_EN
   logic [N-1:0]    MASK;
`endif
   logic [W-1:0]    DOUT;
   logic            DOUT_VALID;
   logic [SELW-1:0] CH_OUT;
   logic            WRAP;

   // Source side: drives channel data and controls, observes the selected output.
   modport master (
`ifdef MUX_MASK_EN
      output MASK,
`endif
      output EN, MODE, SEL, DIN,
      input  DOUT, DOUT_VALID, CH_OUT, WRAP
   );

   // Mux side.
   modport slave (
`ifdef MUX_MASK_EN
      input  MASK,
`endif
      input  EN, MODE, SEL, DIN,
      output DOUT, DOUT_VALID, CH_OUT, WRAP
   );
endinterface

// File: rtl/mux_n_to_1_scan.sv
// Registered N-to-1 mux with manual select or round-robin auto-scan (DWELL cycles per channel).
// Latency: 1 cycle from DIN/SEL/pointer sample to DOUT/CH_OUT.
// Backpressure: none; EN low freezes all state and drops DOUT_VALID. Macro MUX_MASK_EN adds MASK.
module mux_n_to_1_scan #(
   parameter int N     = 4,
   parameter int W     = 1,
   parameter int DWELL = 1
) (
   input logic             CLK,
   input logic             RST,
   mux_n_to_1_scan_if.slave bus
);
   localparam int SELW = $clog2(N);
   localparam int CW   = (DWELL > 1) ? $clog2(DWELL) : 1;

   logic [W-1:0]    dout_q, dout_d;
   logic            dout_vld_q, dout_vld_d;
   logic [SELW-1:0] ch_out_q, ch_out_d;
   logic            wrap_q, wrap_d;
   logic [SELW-1:0] ptr_q, ptr_d;
   logic [CW-1:0]   dcnt_q, dcnt_d;
   // Set when the pointer has wrapped; consumed by the first valid output afterwards.
   logic            wrap_pend_q, wrap_pend_d;
   // Mode seen at the last enabled edge; a 0->1 change reloads the pointer from SEL.
   logic            was_auto_q, was_auto_d;

   logic [N-1:0]    mask;
   logic [SELW-1:0] ptr_e, nxt;
   logic [CW-1:0]   dcnt_e;
   logic            pend_e;

`ifdef MUX_MASK_EN
   assign mask = bus.MASK;
`else
   assign mask = '1;
`endif

   function automatic logic [W-1:0] chan(input logic [N*W-1:0] din, input logic [SELW-1:0] idx);
      return din[int'(idx)*W +: W];
   endfunction

   // Next enabled index after p, modulo N; stays on p if no other channel is enabled.
   function automatic logic [SELW-1:0] next_ch(input logic [SELW-1:0] p, input logic [N-1:0] m);
      logic [SELW-1:0] r;
      int idx;
      r = p;
      for (int i = N - 1; i >= 1; i--) begin
         idx = int'(p) + i;
         if (idx >= N) idx = idx - N;
         if (m[idx]) r = SELW'(idx);
      end
      return r;
   endfunction

   // Next-state: manual select, or auto-scan with dwell count, skip of masked channels and wrap tracking.
   always_comb begin
      dout_d      = dout_q;
      dout_vld_d  = 1'b0;
      ch_out_d    = ch_out_q;
      wrap_d      = 1'b0;
      ptr_d       = ptr_q;
      dcnt_d      = dcnt_q;
      wrap_pend_d = wrap_pend_q;
      was_auto_d  = was_auto_q;
      ptr_e       = ptr_q;
      dcnt_e      = dcnt_q;
      pend_e      = wrap_pend_q;
      nxt         = ptr_q;
      if (bus.EN) begin
         was_auto_d = bus.MODE;
         if (!bus.MODE) begin
            ch_out_d    = bus.SEL;
            wrap_pend_d = 1'b0;
            if (int'(bus.SEL) < N && mask[bus.SEL]) begin
               dout_d     = chan(bus.DIN, bus.SEL);
               dout_vld_d = 1'b1;
            end else begin
               dout_d = '0;
            end
         end else begin
            // Entering auto: the loaded pointer is used at this very edge.
            if (!was_auto_q) begin
               ptr_e  = (int'(bus.SEL) < N) ? bus.SEL : '0;
               dcnt_e = '0;
               pend_e = 1'b0;
            end
            nxt         = next_ch(ptr_e, mask);
            ch_out_d    = ptr_e;
            ptr_d       = ptr_e;
            dcnt_d      = dcnt_e;
            wrap_pend_d = pend_e;
            if (mask == '0) begin
               dout_d = '0;
            end else if (!mask[ptr_e]) begin
               dout_d      = '0;
               ptr_d       = nxt;
               dcnt_d      = '0;
               wrap_pend_d = pend_e | (nxt <= ptr_e);
            end else begin
               dout_d      = chan(bus.DIN, ptr_e);
               dout_vld_d  = 1'b1;
               wrap_d      = pend_e;
               wrap_pend_d = 1'b0;
               if (dcnt_e == CW'(DWELL - 1)) begin
                  dcnt_d = '0;
                  ptr_d  = nxt;
                  if (nxt <= ptr_e) wrap_pend_d = 1'b1;
               end else begin
                  dcnt_d = dcnt_e + 1'b1;
               end
            end
         end
      end
   end

   // State registers with synchronous reset; after reset the scan starts at channel 0.
   always_ff @(posedge CLK) begin
      if (RST) begin
         dout_q      <= '0;
         dout_vld_q  <= 1'b0;
         ch_out_q    <= '0;
         wrap_q      <= 1'b0;
         ptr_q       <= '0;
         dcnt_q      <= '0;
         wrap_pend_q <= 1'b0;
         was_auto_q  <= 1'b1;
      end else begin
         dout_q      <= dout_d;
         dout_vld_q  <= dout_vld_d;
         ch_out_q    <= ch_out_d;
         wrap_q      <= wrap_d;
         ptr_q       <= ptr_d;
         dcnt_q      <= dcnt_d;
         wrap_pend_q <= wrap_pend_d;
         was_auto_q  <= was_auto_d;
      end
   end

   assign bus.DOUT       = dout_q;
   assign bus.DOUT_VALID = dout_vld_q;
   assign bus.CH_OUT     = ch_out_q;
   assign bus.WRAP       = wrap_q;
endmodule
